// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, NOP encoding, reset PC
// and base opcodes used by fetch, decode and imm_gen.
package core_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_FAULT
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel
// plus the valid/ready channel towards decode.
interface inst_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_inst,
        output if_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_inst,
        input  if_pc
    );

endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, single-outstanding imem FSM, kill flag
// for in-flight responses and a one-entry output slot to decode.
module inst_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_fetch_if.master     bus,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic             fetch_misalign
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            kill, kill_n;
    logic            load;

    logic            valid_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_q;
    logic            misalign_q;

    logic            req;
    logic            launch;
    logic            inflight;
    logic            still_out;
    logic            odd;

    // Only request when the output slot can take the response.
    assign req       = (state == F_REQ) && (!valid_q || bus.if_ready);
    assign launch    = req && bus.imem_gnt;
    assign inflight  = (state == F_WAIT) || kill;
    assign still_out = (inflight && !bus.imem_rvalid) || launch;
    assign odd       = |redirect_target[1:0];

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        load    = 1'b0;

        unique case (state)
            F_IDLE:  state_n = F_REQ;
            F_REQ:   if (launch) state_n = F_WAIT;
            F_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_n = F_REQ;
                    kill_n  = 1'b0;
                    if (!kill) begin
                        load = 1'b1;
                        pc_n = pc + XLEN'(4);
                    end
                end
            end
            F_FAULT: if (bus.imem_rvalid) kill_n = 1'b0;
            default: state_n = F_IDLE;
        endcase

        // A still-pending response must drain before refetching.
        if (redirect_valid) begin
            pc_n   = redirect_target;
            load   = 1'b0;
            kill_n = still_out;
            if (odd)
                state_n = F_FAULT;
            else if (still_out)
                state_n = F_WAIT;
            else
                state_n = F_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= F_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            kill       <= 1'b0;
            valid_q    <= 1'b0;
            inst_q     <= NOP_INST;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc   <= pc_n;
            kill <= kill_n;
            if (redirect_valid) begin
                valid_q    <= 1'b0;
                misalign_q <= odd;
            end else if (load) begin
                valid_q <= 1'b1;
                inst_q  <= bus.imem_rdata;
                pc_q    <= pc;
            end else if (bus.if_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = {pc[XLEN-1:2], 2'b00};
    assign bus.if_valid    = valid_q;
    assign bus.if_inst     = inst_q;
    assign bus.if_pc       = pc_q;
    assign fetch_misalign  = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory responder, stream model checked every
// cycle, and directed reset/stream/stall/redirect/fault scenarios.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_misalign;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_misalign  (fetch_misalign)
    );

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;
    int rel = 0;

    int          lat = 1;
    bit          stale = 0;
    bit          pend = 0;
    logic [31:0] paddr = '0;
    int          due = 0;

    logic [31:0] exp_pc = '0;
    bit          mis = 0;
    bit          hold = 0;
    logic [31:0] hold_pc = '0;
    logic [31:0] hold_inst = '0;

    logic [31:0] log_pc[$];
    logic [31:0] log_inst[$];
    int          log_cyc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [31:0] memword(logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        if (a == 32'h4) return 32'h00B0_0113;
        return (a << 7) | 32'h13;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        ntotal++;
        if (got === exp)
            npass++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
    endtask

    // Instruction memory: fixed latency, one response per grant.
    always @(negedge clk) begin
        bus.imem_rvalid = 1'b0;
        if (pend && cyc == due) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = stale ? 32'hDEAD_BEEF : memword(paddr);
            stale = 0;
            pend  = 0;
        end
        if (bus.imem_req && bus.imem_gnt) begin
            chk("single_outstanding", {31'b0, pend}, 32'd0);
            pend  = 1;
            paddr = bus.imem_addr;
            due   = cyc + lat;
        end
    end

    // Stream model: decode must see consecutive words from the last
    // redirect target (or reset PC), each paired with its own address.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 32'h0;
            mis    = 0;
            hold   = 0;
            log_pc.delete();
            log_inst.delete();
            log_cyc.delete();
        end else begin
            if (mis) begin
                chk("misalign_set", {31'b0, fetch_misalign}, 32'd1);
                chk("fault_req", {31'b0, bus.imem_req}, 32'd0);
                chk("fault_valid", {31'b0, bus.if_valid}, 32'd0);
            end else begin
                chk("misalign_clr", {31'b0, fetch_misalign}, 32'd0);
            end
            if (bus.imem_req)
                chk("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
            if (hold) begin
                chk("hold_valid", {31'b0, bus.if_valid}, 32'd1);
                chk("hold_pc", bus.if_pc, hold_pc);
                chk("hold_inst", bus.if_inst, hold_inst);
            end
            if (bus.if_valid && bus.if_ready && !redirect_valid) begin
                chk("stream_pc", bus.if_pc, exp_pc);
                chk("stream_inst", bus.if_inst, memword(exp_pc));
                log_pc.push_back(bus.if_pc);
                log_inst.push_back(bus.if_inst);
                log_cyc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
            hold      = bus.if_valid && !bus.if_ready && !redirect_valid;
            hold_pc   = bus.if_pc;
            hold_inst = bus.if_inst;
            if (redirect_valid) begin
                exp_pc = redirect_target;
                mis    = (redirect_target[1:0] != 2'b00);
            end
        end
    end

    task automatic do_reset(int n);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
    endtask

    task automatic wait_log(int n);
        int k = 0;
        while (log_pc.size() < n && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("wait_log", {31'b0, log_pc.size() >= n}, 32'd1);
    endtask

    task automatic wait_grant();
        int k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (!(bus.imem_req && bus.imem_gnt) && k < 50);
        chk("wait_grant", {31'b0, bus.imem_req && bus.imem_gnt}, 32'd1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.if_valid && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("wait_valid", {31'b0, bus.if_valid}, 32'd1);
    endtask

    task automatic pulse_redirect(logic [31:0] t);
        @(posedge clk); #1;
        redirect_valid  = 1'b1;
        redirect_target = t;
        @(posedge clk); #1;
        redirect_valid  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.if_ready    = 1'b1;

        // Reset values, then one idle cycle before the first request.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst_inst", bus.if_inst, 32'h0000_0013);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rel = cyc;
        @(negedge clk); #1;
        chk("idle_req", {31'b0, bus.imem_req}, 32'd0);
        @(negedge clk); #1;
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);

        // Streaming at one instruction per two cycles.
        wait_log(3);
        chk("s_pc0", log_pc[0], 32'h0);
        chk("s_pc1", log_pc[1], 32'h4);
        chk("s_pc2", log_pc[2], 32'h8);
        chk("s_inst0", log_inst[0], 32'h00A0_0093);
        chk("s_inst1", log_inst[1], 32'h00B0_0113);
        chk("s_lat", log_cyc[0] - rel, 32'd3);
        chk("s_gap1", log_cyc[1] - log_cyc[0], 32'd2);
        chk("s_gap2", log_cyc[2] - log_cyc[1], 32'd2);

        // Backpressure on the word at 0x4.
        do_reset(2);
        wait_log(1);
        @(posedge clk); #1;
        bus.if_ready = 1'b0;
        @(negedge clk); #1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_pc", bus.if_pc, 32'h4);
            chk("bp_inst", bus.if_inst, 32'h00B0_0113);
            chk("bp_req", {31'b0, bus.imem_req}, 32'd0);
            @(negedge clk); #1;
        end
        chk("bp_nolog", log_pc.size(), 32'd1);
        @(posedge clk); #1;
        bus.if_ready = 1'b1;
        wait_log(3);
        chk("bp_pc1", log_pc[1], 32'h4);
        chk("bp_pc2", log_pc[2], 32'h8);
        chk("bp_inst2", log_inst[2], 32'h0000_0413);

        // Redirect while waiting; the stale response is dropped.
        lat = 2;
        do_reset(3);
        wait_grant();
        @(posedge clk); #1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        stale = 1;
        @(posedge clk); #1;
        redirect_valid  = 1'b0;
        wait_log(1);
        chk("rd_pc", log_pc[0], 32'h100);
        chk("rd_inst", log_inst[0], 32'h0000_8013);
        chk("rd_stale_sent", {31'b0, stale}, 32'd0);

        // Misaligned target halts; aligned target resumes.
        lat = 1;
        do_reset(3);
        wait_log(1);
        pulse_redirect(32'h102);
        @(negedge clk); #1;
        chk("mis_flag", {31'b0, fetch_misalign}, 32'd1);
        chk("mis_req", {31'b0, bus.imem_req}, 32'd0);
        chk("mis_valid", {31'b0, bus.if_valid}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("mis_flag_held", {31'b0, fetch_misalign}, 32'd1);
        chk("mis_req_held", {31'b0, bus.imem_req}, 32'd0);
        n = log_pc.size();
        pulse_redirect(32'h200);
        @(negedge clk); #1;
        chk("fix_flag", {31'b0, fetch_misalign}, 32'd0);
        chk("fix_req", {31'b0, bus.imem_req}, 32'd1);
        chk("fix_addr", bus.imem_addr, 32'h200);
        wait_log(n + 1);
        chk("fix_pc", log_pc[n], 32'h200);
        chk("fix_inst", log_inst[n], 32'h0001_0013);

        // Reset while a response is in flight.
        lat = 2;
        do_reset(3);
        wait_grant();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        @(negedge clk); #1;
        chk("r6_idle_req", {31'b0, bus.imem_req}, 32'd0);
        chk("r6_valid", {31'b0, bus.if_valid}, 32'd0);
        @(negedge clk); #1;
        chk("r6_req", {31'b0, bus.imem_req}, 32'd1);
        chk("r6_addr", bus.imem_addr, 32'h0);
        wait_log(1);
        chk("r6_pc", log_pc[0], 32'h0);
        chk("r6_inst", log_inst[0], 32'h00A0_0093);
        chk("r6_lat", log_cyc[0] - rel, 32'd4);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
